pll_reconfig_sequencer: RTL and testbench
=========================================

PLL_RECONFIG_SEQUENCER -- requirements
Module: pll_reconfig_sequencer

Interface
REQ-001 SHALL have parameter NUM_OUTPUTS, default 6, meaning the number of PLL outputs scanned (max 8).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 65535, meaning the watchdog limit in clk cycles.
REQ-003 SHALL have port clk  input  1  sole clock; the PLL reconfig port runs on it.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid / req_ready  in / out  1 / 1  profile request handshake.
REQ-006 SHALL have port req_vco_mult, req_vco_indiv  input  7 each  VCO multiplier and input divider.
REQ-007 SHALL have port req_vco_bandwidth  input  1  PLL bandwidth select.
REQ-008 SHALL have port req_out_mask  input  NUM_OUTPUTS  outputs to reprogram.
REQ-009 SHALL have port req_out_div / req_out_phase  input  8*NUM_OUTPUTS / 9*NUM_OUTPUTS  packed per output, index 0 in LSBs.
REQ-010 SHALL have port done / error  output  1 / 1  single-cycle completion / failure pulses.
REQ-011 SHALL have port pll_busy, pll_locked, pll_cmd_done  input  1 each  status from the PLL.
REQ-012 SHALL have port pll_start, pll_finish, pll_vco_en, pll_output_en  output  1 each  single-cycle strobes to the PLL.
REQ-013 SHALL have port pll_vco_mult, pll_vco_indiv (7), pll_vco_bandwidth (1), pll_output_idx (3), pll_output_div (8), pll_output_phase (9)  output  command fields to the PLL.

Function
REQ-014 SHALL have states IDLE, START, VCO, VCO_WAIT, OUT, OUT_WAIT, FINISH, LOCK_WAIT.
REQ-015 SHALL assert req_ready only in IDLE; a request is accepted when req_valid && req_ready, and all request fields are registered on that edge.
REQ-016 SHALL pulse pll_start for one cycle in START, which is entered the cycle after acceptance.
REQ-017 SHALL pulse pll_vco_en in VCO with the registered VCO fields, then hold in VCO_WAIT until pll_cmd_done.
REQ-018 SHALL scan the captured mask in ascending index order in OUT, issuing one pll_output_en per set bit with that bit's idx, div and phase, and waiting for pll_cmd_done in OUT_WAIT after each strobe.
REQ-019 SHALL go directly from VCO_WAIT to FINISH when the captured mask is zero.
REQ-020 SHALL pulse pll_finish for one cycle in FINISH.
REQ-021 SHALL in LOCK_WAIT pulse done and return to IDLE on the first cycle where !pll_busy && pll_locked.
REQ-022 SHALL ignore pll_cmd_done outside VCO_WAIT and OUT_WAIT.
REQ-023 SHALL ignore req_valid outside IDLE, so the request is not accepted.
REQ-024 SHALL never assert done and error in the same cycle.
REQ-025 SHALL hold PLL command fields stable from the strobe until pll_cmd_done.
REQ-026 SHALL have minimum latency from acceptance to pll_vco_en of 2 cycles.

Reset
REQ-027 SHALL on rst_n low force IDLE asynchronously, including mid-sequence.
REQ-028 SHALL reset all strobes, done and error to 0, all command fields to 0, and req_ready to 1 after reset release.

Configuration
REQ-029 SHALL, with PLL_RECONFIG_WATCHDOG_EN defined, count cycles spent in VCO_WAIT, OUT_WAIT and LOCK_WAIT, with the count cleared on every state change.
REQ-030 SHALL, with PLL_RECONFIG_WATCHDOG_EN defined, pulse error and return to IDLE when the count reaches LOCK_TIMEOUT, issuing no pll_finish.
REQ-031 SHALL, without PLL_RECONFIG_WATCHDOG_EN defined, wait indefinitely, tie error to 0 and contain no counter logic.

Structure
REQ-032 SHALL place the state enum, a pll_profile_t struct (VCO fields, mask, div/phase arrays) and the field-width constants in the shared package pll_reconfig_pkg.
REQ-033 SHALL implement the watchdog as sub-module pll_reconfig_watchdog, instantiated only under the macro.

Verification
REQ-034 SHALL test: mult=40, indiv=2, mask=6'b000101 -> order start, vco, out idx0, out idx2, finish; with locked high, done 1 cycle later.
REQ-035 SHALL test: mask=0 -> pll_output_en never asserted; pll_finish follows pll_cmd_done for the VCO command.
REQ-036 SHALL test: req_valid held high during the sequence -> exactly one acceptance; a second acceptance only after done.
REQ-037 SHALL test: rst_n low during OUT_WAIT -> all outputs 0 immediately; req_ready=1 after release; no stale strobes.
REQ-038 SHALL test, with the macro and LOCK_TIMEOUT=100: pll_locked stuck low -> error exactly 100 cycles into LOCK_WAIT, done never asserted.
REQ-039 SHALL test: spurious pll_cmd_done in IDLE -> no state change.

Source files
------------

// File: rtl/pll_reconfig_pkg.sv
// Shared types and field widths for the PLL reconfiguration sequencer.
package pll_reconfig_pkg;

  localparam int unsigned MaxOutputs = 8;
  localparam int unsigned VcoW       = 7;
  localparam int unsigned IdxW       = 3;
  localparam int unsigned DivW       = 8;
  localparam int unsigned PhaseW     = 9;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StVco,
    StVcoWait,
    StOut,
    StOutWait,
    StFinish,
    StLockWait
  } state_e;

  // Per-output arrays are sized for the maximum; unused entries stay zero.
  typedef struct packed {
    logic [VcoW-1:0]                     vco_mult;
    logic [VcoW-1:0]                     vco_indiv;
    logic                                vco_bandwidth;
    logic [MaxOutputs-1:0]               mask;
    logic [MaxOutputs-1:0][DivW-1:0]     div;
    logic [MaxOutputs-1:0][PhaseW-1:0]   phase;
  } pll_profile_t;

  function automatic logic [IdxW-1:0] lowest_set(input logic [MaxOutputs-1:0] m);
    logic [IdxW-1:0] idx;
    idx = '0;
    for (int i = MaxOutputs - 1; i >= 0; i--) begin
      if (m[i]) idx = IdxW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/pll_reconfig_watchdog.sv
// Cycle counter for the PLL wait states; expires after LOCK_TIMEOUT counted cycles.
module pll_reconfig_watchdog #(
  parameter int unsigned LOCK_TIMEOUT = 65535
) (
  input  logic clk,
  input  logic rst_n,
  input  logic count_en_i,
  input  logic clear_i,
  output logic expired_o
);

  // Only values up to LOCK_TIMEOUT-1 are ever held.
  localparam int unsigned CntW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_en_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = count_en_i && (cnt_q == CntW'(LOCK_TIMEOUT - 1));

endmodule

// File: rtl/pll_reconfig_sequencer.sv
// Sequences a captured PLL profile onto the reconfig port: start, VCO, outputs, finish, lock.
// Optional lock/command watchdog enabled by defining PLL_RECONFIG_WATCHDOG_EN.
module pll_reconfig_sequencer
  import pll_reconfig_pkg::*;
#(
  parameter int unsigned NUM_OUTPUTS  = 6,
  parameter int unsigned LOCK_TIMEOUT = 65535
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [6:0]                    req_vco_mult,
  input  logic [6:0]                    req_vco_indiv,
  input  logic                          req_vco_bandwidth,
  input  logic [NUM_OUTPUTS-1:0]        req_out_mask,
  input  logic [8*NUM_OUTPUTS-1:0]      req_out_div,
  input  logic [9*NUM_OUTPUTS-1:0]      req_out_phase,
  output logic                          done,
  output logic                          error,
  input  logic                          pll_busy,
  input  logic                          pll_locked,
  input  logic                          pll_cmd_done,
  output logic                          pll_start,
  output logic                          pll_finish,
  output logic                          pll_vco_en,
  output logic                          pll_output_en,
  output logic [6:0]                    pll_vco_mult,
  output logic [6:0]                    pll_vco_indiv,
  output logic                          pll_vco_bandwidth,
  output logic [2:0]                    pll_output_idx,
  output logic [7:0]                    pll_output_div,
  output logic [8:0]                    pll_output_phase
);

  state_e                  state_q, state_d;
  pll_profile_t            prof_q, prof_d;
  logic [MaxOutputs-1:0]   rem_q, rem_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [MaxOutputs-1:0]   idx_bit;
  logic                    err;
  logic                    wd_expired;

  logic [MaxOutputs-1:0]             req_mask_ext;
  logic [MaxOutputs-1:0][DivW-1:0]   req_div_ext;
  logic [MaxOutputs-1:0][PhaseW-1:0] req_phase_ext;

  // Widen the request to the package's fixed-size profile.
  for (genvar i = 0; i < MaxOutputs; i++) begin : g_ext
    if (i < NUM_OUTPUTS) begin : g_used
      assign req_mask_ext[i]  = req_out_mask[i];
      assign req_div_ext[i]   = req_out_div[DivW*i +: DivW];
      assign req_phase_ext[i] = req_out_phase[PhaseW*i +: PhaseW];
    end else begin : g_unused
      assign req_mask_ext[i]  = 1'b0;
      assign req_div_ext[i]   = '0;
      assign req_phase_ext[i] = '0;
    end
  end

  always_comb begin
    idx_bit        = '0;
    idx_bit[idx_q] = 1'b1;
  end

  always_comb begin
    state_d       = state_q;
    prof_d        = prof_q;
    rem_d         = rem_q;
    idx_d         = idx_q;
    pll_start     = 1'b0;
    pll_vco_en    = 1'b0;
    pll_output_en = 1'b0;
    pll_finish    = 1'b0;
    done          = 1'b0;
    err           = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          prof_d.vco_mult      = req_vco_mult;
          prof_d.vco_indiv     = req_vco_indiv;
          prof_d.vco_bandwidth = req_vco_bandwidth;
          prof_d.mask          = req_mask_ext;
          prof_d.div           = req_div_ext;
          prof_d.phase         = req_phase_ext;
          state_d              = StStart;
        end
      end
      StStart: begin
        pll_start = 1'b1;
        state_d   = StVco;
      end
      StVco: begin
        pll_vco_en = 1'b1;
        state_d    = StVcoWait;
      end
      StVcoWait: begin
        if (wd_expired) begin
          err     = 1'b1;
          state_d = StIdle;
        end else if (pll_cmd_done) begin
          if (prof_q.mask == '0) begin
            state_d = StFinish;
          end else begin
            rem_d   = prof_q.mask;
            idx_d   = lowest_set(prof_q.mask);
            state_d = StOut;
          end
        end
      end
      StOut: begin
        pll_output_en = 1'b1;
        rem_d         = rem_q & ~idx_bit;
        state_d       = StOutWait;
      end
      StOutWait: begin
        if (wd_expired) begin
          err     = 1'b1;
          state_d = StIdle;
        end else if (pll_cmd_done) begin
          if (rem_q == '0) begin
            state_d = StFinish;
          end else begin
            idx_d   = lowest_set(rem_q);
            state_d = StOut;
          end
        end
      end
      StFinish: begin
        pll_finish = 1'b1;
        state_d    = StLockWait;
      end
      StLockWait: begin
        // A lock seen on the expiry cycle still counts as success.
        if (!pll_busy && pll_locked) begin
          done    = 1'b1;
          state_d = StIdle;
        end else if (wd_expired) begin
          err     = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      prof_q  <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      prof_q  <= prof_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
    end
  end

  assign req_ready         = (state_q == StIdle);
  assign pll_vco_mult      = prof_q.vco_mult;
  assign pll_vco_indiv     = prof_q.vco_indiv;
  assign pll_vco_bandwidth = prof_q.vco_bandwidth;
  assign pll_output_idx    = idx_q;
  assign pll_output_div    = prof_q.div[idx_q];
  assign pll_output_phase  = prof_q.phase[idx_q];

`ifdef PLL_RECONFIG_WATCHDOG_EN
  logic wd_count_en;
  logic wd_clear;

  assign wd_count_en = (state_q == StVcoWait) || (state_q == StOutWait) ||
                       (state_q == StLockWait);
  assign wd_clear    = (state_d != state_q);

  pll_reconfig_watchdog #(
    .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .count_en_i(wd_count_en),
    .clear_i   (wd_clear),
    .expired_o (wd_expired)
  );

  assign error = err;
`else
  logic unused_cfg;

  assign wd_expired = 1'b0;
  assign error      = 1'b0;
  assign unused_cfg = ^{err, LOCK_TIMEOUT[0]};
`endif

endmodule

// File: tb/tb_pll_reconfig_sequencer.sv
// Directed self-checking bench for pll_reconfig_sequencer (NUM_OUTPUTS=6, LOCK_TIMEOUT=100).
module tb_pll_reconfig_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  req_vco_mult;
  logic [6:0]  req_vco_indiv;
  logic        req_vco_bandwidth;
  logic [5:0]  req_out_mask;
  logic [47:0] req_out_div;
  logic [53:0] req_out_phase;
  logic        done;
  logic        error;
  logic        pll_busy;
  logic        pll_locked;
  logic        pll_cmd_done;
  logic        pll_start;
  logic        pll_finish;
  logic        pll_vco_en;
  logic        pll_output_en;
  logic [6:0]  pll_vco_mult;
  logic [6:0]  pll_vco_indiv;
  logic        pll_vco_bandwidth;
  logic [2:0]  pll_output_idx;
  logic [7:0]  pll_output_div;
  logic [8:0]  pll_output_phase;

  int checks   = 0;
  int failures = 0;
  int acc_cnt  = 0;
  int acc_base = 0;
  int err_seen = 0;
  int done_seen = 0;
  bit started  = 1'b0;

  pll_reconfig_sequencer #(
    .NUM_OUTPUTS (6),
    .LOCK_TIMEOUT(100)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_vco_mult     (req_vco_mult),
    .req_vco_indiv    (req_vco_indiv),
    .req_vco_bandwidth(req_vco_bandwidth),
    .req_out_mask     (req_out_mask),
    .req_out_div      (req_out_div),
    .req_out_phase    (req_out_phase),
    .done             (done),
    .error            (error),
    .pll_busy         (pll_busy),
    .pll_locked       (pll_locked),
    .pll_cmd_done     (pll_cmd_done),
    .pll_start        (pll_start),
    .pll_finish       (pll_finish),
    .pll_vco_en       (pll_vco_en),
    .pll_output_en    (pll_output_en),
    .pll_vco_mult     (pll_vco_mult),
    .pll_vco_indiv    (pll_vco_indiv),
    .pll_vco_bandwidth(pll_vco_bandwidth),
    .pll_output_idx   (pll_output_idx),
    .pll_output_div   (pll_output_div),
    .pll_output_phase (pll_output_phase)
  );

  always #5 clk = ~clk;

  logic [5:0]  strobes;
  logic [34:0] fields;
  assign strobes = {pll_start, pll_finish, pll_vco_en, pll_output_en, done, error};
  assign fields  = {pll_vco_mult, pll_vco_indiv, pll_vco_bandwidth, pll_output_idx,
                    pll_output_div, pll_output_phase};

  always @(posedge clk) begin
    if (rst_n && req_valid && req_ready) acc_cnt++;
  end

  always @(negedge clk) begin
    if (started) begin
      checks++;
      assert (!(done && error)) else begin
        failures++;
        $error("FAIL done_error_exclusive: observed done=%0b error=%0b required not both",
               done, error);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_vco_mult = '0;
    req_vco_indiv = '0;
    req_vco_bandwidth = 1'b0;
    req_out_mask = '0;
    pll_busy = 1'b0;
    pll_locked = 1'b0;
    pll_cmd_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      req_out_div[8*i +: 8]   = 8'(10 + i);
      req_out_phase[9*i +: 9] = 9'(3 * i + 1);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    started = 1'b1;
    check("reset_ready", req_ready, 1);
    check("reset_strobes", strobes, 0);
    check("reset_fields", fields, 0);

    // Profile: mult=40 indiv=2, outputs 0 and 2
    req_vco_mult = 7'd40;
    req_vco_indiv = 7'd2;
    req_vco_bandwidth = 1'b1;
    req_out_mask = 6'b000101;
    pll_locked = 1'b1;
    req_valid = 1'b1;
    step();
    check("t1_start", pll_start, 1);
    check("t1_ready_low", req_ready, 0);
    req_valid = 1'b0;
    step();
    check("t1_vco_en", pll_vco_en, 1);
    check("t1_vco_fields", {pll_vco_mult, pll_vco_indiv, pll_vco_bandwidth},
          {7'd40, 7'd2, 1'b1});
    step();
    check("t1_vco_en_pulse", pll_vco_en, 0);
    check("t1_vco_hold", pll_vco_mult, 40);
    step();
    check("t1_vco_wait", strobes, 0);
    pll_cmd_done = 1'b1;
    step();
    pll_cmd_done = 1'b0;
    check("t1_out0_en", pll_output_en, 1);
    check("t1_out0_fields", {pll_output_idx, pll_output_div, pll_output_phase},
          {3'd0, 8'd10, 9'd1});
    step();
    check("t1_out0_wait", pll_output_en, 0);
    pll_cmd_done = 1'b1;
    step();
    pll_cmd_done = 1'b0;
    check("t1_out2_en", pll_output_en, 1);
    check("t1_out2_fields", {pll_output_idx, pll_output_div, pll_output_phase},
          {3'd2, 8'd12, 9'd7});
    step();
    pll_cmd_done = 1'b1;
    step();
    pll_cmd_done = 1'b0;
    check("t1_finish", {pll_finish, pll_output_en}, 2'b10);
    step();
    check("t1_done", {done, error, pll_finish}, 3'b100);
    step();
    check("t1_idle", {req_ready, done}, 2'b10);

    // Spurious cmd_done in idle, then a zero-mask profile
    pll_cmd_done = 1'b1;
    step();
    pll_cmd_done = 1'b0;
    check("t2_spurious_ready", req_ready, 1);
    check("t2_spurious_strobes", strobes, 0);
    req_out_mask = 6'b000000;
    req_vco_mult = 7'd5;
    pll_busy = 1'b1;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    check("t2_vco_mult", pll_vco_mult, 5);
    step();
    check("t2_no_out", pll_output_en, 0);
    pll_cmd_done = 1'b1;
    step();
    pll_cmd_done = 1'b0;
    check("t2_finish", {pll_finish, pll_output_en}, 2'b10);
    step();
    check("t2_busy_no_done", done, 0);
    step();
    check("t2_busy_hold", {done, req_ready}, 2'b00);
    pll_busy = 1'b0;
    #1;
    check("t2_done", done, 1);
    step();
    check("t2_idle", req_ready, 1);

    // req_valid held high across a whole sequence
    req_out_mask = 6'b000010;
    acc_base = acc_cnt;
    req_valid = 1'b1;
    step();
    check("t3_acc_first", acc_cnt - acc_base, 1);
    step();
    step();
    pll_cmd_done = 1'b1;
    step();
    pll_cmd_done = 1'b0;
    check("t3_out1_idx", pll_output_idx, 1);
    step();
    pll_cmd_done = 1'b1;
    step();
    pll_cmd_done = 1'b0;
    step();
    check("t3_done", done, 1);
    check("t3_acc_during", acc_cnt - acc_base, 1);
    step();
    check("t3_acc_idle", acc_cnt - acc_base, 1);
    step();
    check("t3_acc_second", acc_cnt - acc_base, 2);
    check("t3_second_start", pll_start, 1);
    req_valid = 1'b0;

    // Reset while waiting on an output command
    step();
    step();
    pll_cmd_done = 1'b1;
    step();
    pll_cmd_done = 1'b0;
    step();
    check("t4_pre_reset_fields", {pll_output_idx, pll_output_div}, {3'd1, 8'd11});
    rst_n = 1'b0;
    #1;
    check("t4_reset_strobes", strobes, 0);
    check("t4_reset_fields", fields, 0);
    step();
    rst_n = 1'b1;
    #1;
    check("t4_release_ready", req_ready, 1);
    pll_cmd_done = 1'b1;
    step();
    pll_cmd_done = 1'b0;
    check("t4_no_stale", strobes, 0);
    step();
    check("t4_still_idle", {req_ready, strobes}, 7'b1000000);

    // Lock never arrives
    pll_locked = 1'b0;
    req_out_mask = '0;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    step();
    pll_cmd_done = 1'b1;
    step();
    pll_cmd_done = 1'b0;
    check("t5_finish", pll_finish, 1);
    step();
`ifdef PLL_RECONFIG_WATCHDOG_EN
    for (int i = 1; i < 100; i++) begin
      if (error) err_seen++;
      if (done) done_seen++;
      step();
    end
    check("t5_no_early_error", err_seen, 0);
    check("t5_error_at_100", {error, done, pll_finish}, 3'b100);
    step();
    check("t5_idle_after_error", {req_ready, error}, 2'b10);
    check("t5_no_done", done_seen, 0);
`else
    for (int i = 0; i < 150; i++) begin
      if (error) err_seen++;
      if (done) done_seen++;
      step();
    end
    check("t5_no_error", err_seen, 0);
    check("t5_no_done", done_seen, 0);
    check("t5_still_waiting", req_ready, 0);
    pll_locked = 1'b1;
    #1;
    check("t5_late_lock_done", done, 1);
    step();
    check("t5_idle", req_ready, 1);
`endif

    started = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
